spram_fifo_ctrl: RTL

- Controller that turns one single-port RAM (1-cycle read latency, one access per cycle) into a FIFO.
- Owns write/read pointers and occupancy, and drives the RAM's ena/wea/addr/din.
- Arbitrates push and pop because the RAM port takes only one access per cycle; contested cycles are resolved round-robin.
- Sits between a producer and a consumer in the fifo_with_spram subsystem.

---
 rtl/spram_fifo_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/spram_fifo_ctrl.sv
// FIFO controller over a 1-cycle-latency single-port RAM; push/pop share the port, contested cycles round-robin.
// Pop data returns 2 cycles after acceptance; full/empty deassert ready. Error flags built only with SPRAM_FIFO_ERR_EN.
module spram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop_req,
  output logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  ram_read_valid,
  input  logic                  err_clr,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  typedef enum logic {PRIO_PUSH = 1'b0, PRIO_POP = 1'b1} prio_t;

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  prio_t                 r_prio;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_pop_data;
  logic                  r_pop_vld;

  logic w_push_elig;
  logic w_pop_elig;
  logic w_push_gnt;
  logic w_pop_gnt;
  logic w_contested;

  assign full  = (r_count == LP_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;

  assign w_push_elig = push_valid & ~full;
  assign w_pop_elig  = pop_req & ~empty;
  assign w_contested = w_push_elig & w_pop_elig;
  assign w_push_gnt  = w_push_elig & (~w_pop_elig | (r_prio == PRIO_PUSH));
  assign w_pop_gnt   = w_pop_elig & (~w_push_elig | (r_prio == PRIO_POP));

  assign push_ready     = w_push_gnt;
  assign pop_ready      = w_pop_gnt;
  assign pop_data       = r_pop_data;
  assign pop_data_valid = r_pop_vld;

  always_comb begin
    ram_ena  = 1'b0;
    ram_wea  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (w_push_gnt) begin
      ram_ena  = 1'b1;
      ram_wea  = 1'b1;
      ram_addr = r_wr_ptr;
      ram_din  = push_data;
    end else if (w_pop_gnt) begin
      ram_ena  = 1'b1;
      ram_addr = r_rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_prio   <= PRIO_PUSH;
    end else begin
      if (w_push_gnt) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
        r_count  <= r_count + (ADDR_WIDTH + 1)'(1);
      end else if (w_pop_gnt) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
        r_count  <= r_count - (ADDR_WIDTH + 1)'(1);
      end
      // Hand priority to whichever side just lost.
      if (w_contested) begin
        r_prio <= (r_prio == PRIO_PUSH) ? PRIO_POP : PRIO_PUSH;
      end
    end
  end

  // Pending bit drops any read still in flight across a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pop_data <= '0;
      r_pop_vld  <= 1'b0;
    end else begin
      r_pend <= w_pop_gnt;
      if (ram_read_valid & r_pend) begin
        r_pop_data <= ram_dout;
        r_pop_vld  <= 1'b1;
      end else begin
        r_pop_vld  <= 1'b0;
      end
    end
  end

`ifdef SPRAM_FIFO_ERR_EN
  logic r_overflow_err;
  logic r_underflow_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (push_valid & full) r_overflow_err <= 1'b1;
      else if (err_clr)      r_overflow_err <= 1'b0;
      if (pop_req & empty)   r_underflow_err <= 1'b1;
      else if (err_clr)      r_underflow_err <= 1'b0;
    end
  end

  assign overflow_err  = r_overflow_err;
  assign underflow_err = r_underflow_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign overflow_err     = 1'b0;
  assign underflow_err    = 1'b0;
`endif

endmodule
